wb_arb2: RTL
============

# wb_arb2

Two-master Wishbone arbiter that merges the core's data port (m0) and instruction port (m1) onto one Wishbone master port into the bus interconnect. Ownership is granted per bus cycle (CYC) with round-robin fairness, and the owner's signals are muxed through to the slave side. An optional watchdog aborts cycles that receive no ACK/ERR/RTY.

## Interface
Parameters:
- AW, 32: address width.
- DW, 32: data width; SEL width is DW/8.
- TIMEOUT, 255: watchdog limit in clock cycles. Range 2..65535.

Ports (clock and reset first):
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- m0_addr_i / m1_addr_i  in  AW  master address.
- m0_data_i / m1_data_i  in  DW  master write data.
- m0_sel_i / m1_sel_i  in  DW/8  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  bus cycle.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_data_o / m1_data_o  out  DW  read data; both are driven with s_data_i.
- m0_ack_o / m1_ack_o  out  1  acknowledge; owner only.
- m0_err_o / m1_err_o  out  1  error; owner only.
- m0_rty_o / m1_rty_o  out  1  retry; owner only.
- s_addr_o  out  AW  owner address.
- s_data_o  out  DW  owner write data.
- s_sel_o  out  DW/8  owner byte selects.
- s_we_o  out  1  owner write enable.
- s_cyc_o  out  1  owner cycle.
- s_stb_o  out  1  owner strobe.
- s_data_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.
- s_rty_i  in  1  slave retry.
- gnt_o  out  2  one-hot current owner; 00 when idle or aborting.

## Operation
- Request: mN_req = mN_cyc_i & mN_stb_i.
- States: IDLE, OWN0, OWN1, ABORT. State is registered.
- IDLE:
  - Only one master requesting: go to that master's OWN state.
  - Both requesting: grant the master that was not granted last. The last-owner flag resets to 1, so m0 wins the first tie.
  - Neither requesting: stay in IDLE.
- OWNn:
  - s_* outputs mirror master n combinationally.
  - mN_ack_o = s_ack_i & mN_stb_i; err_o and rty_o are gated the same way.
  - The non-owner's ack, err and rty are 0.
  - The owner may issue back-to-back strobes within the held CYC.
- Leaving OWNn: when mN_cyc_i is low, update the last-owner flag to n. Next state is OWN(other) if the other master is requesting, otherwise IDLE.
- A non-owner request is held off until the current cycle ends; the non-owner sees no ack.
- IDLE and ABORT outputs: s_cyc_o = s_stb_o = s_we_o = 0; s_addr_o, s_data_o and s_sel_o = 0.
- Slave responses arriving while in IDLE are dropped.
- Reset values: state IDLE, last-owner flag 1, gnt_o = 00, every output 0 except m*_data_o, which follows s_data_i.
- Reset mid-cycle: the next state is IDLE and s_cyc_o falls on the following cycle. The master is responsible for discarding its transfer.

## Timing
- Grant latency: a request seen in IDLE at edge k gives s_cyc_o = 1 in cycle k+1.
- The ack path from slave to master is combinational, so there is zero added latency per beat.
- Handover:
  - OWN to OWN(other) when the owner drops CYC: no idle cycle.
  - OWN to IDLE to a new grant: one dead cycle.
- gnt_o is registered and equals the state encoding.

## Configuration
- Macro: WB_ARB2_TIMEOUT_EN.
- Defined, counter behaviour:
  - A 16-bit counter is cleared in IDLE, on any ack/err/rty, and whenever the owner's stb is low.
  - Otherwise it increments while in OWNn.
  - When the count reaches TIMEOUT-1 and no response is present: pulse mN_err_o for one cycle and go to ABORT.
- Defined, ABORT behaviour:
  - Lasts exactly one cycle with s_cyc_o forced low.
  - Then go to IDLE and set the last-owner flag to the aborted master.
- Not defined: no counter and no ABORT state. The owner keeps the bus indefinitely, and err reflects s_err_i only.

## Structure
- Package wb_arb2_pkg:
  - State enum: IDLE, OWN0, OWN1, ABORT.
  - Constant TIMEOUT_CW = 16.
- The request/tie-break logic is a natural sub-module, rr_pick2: inputs req[1:0] and last, output one-hot pick[1:0].
- The mux, FSM and watchdog stay in wb_arb2.

## Test plan
- Single master: m0 reads 0x3000_0010 while m1 is idle → s_cyc_o rises one cycle later, s_addr_o = 0x3000_0010. With s_ack_i = 1 and s_data_i = 0xDEADBEEF, m0_ack_o = 1 and m0_data_o = 0xDEADBEEF.
- Simultaneous first request after reset: m0 is granted first (gnt_o = 01). When m0 drops CYC, gnt_o = 10 on the next cycle with no dead cycle.
- Fairness: both masters request continuously, each cycle one beat long → grants alternate 01, 10, 01, 10, and m1_ack_o is never 1 while gnt_o = 01.
- Mid-cycle hold-off: m1 requests while m0 is doing 3 back-to-back writes under one CYC → m1 waits, all 3 writes complete on the slave side, then m1 is granted.
- Watchdog, with TIMEOUT = 8 and WB_ARB2_TIMEOUT_EN defined: slave never acks → m0_err_o pulses once 8 cycles after the grant, s_cyc_o is low for 1 cycle, state returns to IDLE. Without the macro, the bus stays held for over 100 cycles.
- Reset mid-cycle: assert wb_rst_i during OWN1 → s_cyc_o = 0 and gnt_o = 00 the next cycle. After release, a tie grants m0.

Source files
------------

// File: rtl/wb_arb2_pkg.sv
// wb_arb2_pkg: shared types and constants for the two-master Wishbone arbiter.
// The state encoding is chosen so that bits [1:0] double as the one-hot grant.
package wb_arb2_pkg;

   localparam int TIMEOUT_CW = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      OWN0  = 3'b001,
      OWN1  = 3'b010,
      ABORT = 3'b100
   } arb_state_t;

   // One-hot grant view of a state; IDLE and ABORT both map to 2'b00.
   function automatic logic [1:0] gnt_of(input arb_state_t s);
      return s[1:0];
   endfunction

endpackage

// File: rtl/wb_arb2_rr_pick2.sv
// rr_pick2: two-way round-robin pick. A lone requester wins; on a tie the
// master that did not own the bus last wins (last = 1 means m1 owned last).
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   // Tie-break against the previous owner, otherwise pass the request through.
   always_comb begin
      pick = req;
      if (req == 2'b11) pick = last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter (m0 = data port, m1 = instruction port)
// with per-CYC ownership and round-robin fairness.
// Optional feature: define WB_ARB2_TIMEOUT_EN to enable the no-response
// watchdog, which errors the owner and aborts the cycle via the ABORT state.
module wb_arb2
   import wb_arb2_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [AW-1:0]   m0_addr_i,
   input  logic [DW-1:0]   m0_data_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_data_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   output logic            m0_rty_o,
   input  logic [AW-1:0]   m1_addr_i,
   input  logic [DW-1:0]   m1_data_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_data_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic            m1_rty_o,
   output logic [AW-1:0]   s_addr_o,
   output logic [DW-1:0]   s_data_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_data_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   input  logic            s_rty_i,
   output logic [1:0]      gnt_o
);

   arb_state_t r_state, w_state_nxt;
   logic       r_last, w_last_nxt;
   logic       w_req0, w_req1;
   logic [1:0] w_pick;
   logic       w_own0, w_own1;
   logic       w_resp;
   logic       w_to_hit;

   assign w_req0 = m0_cyc_i & m0_stb_i;
   assign w_req1 = m1_cyc_i & m1_stb_i;
   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);
   assign w_resp = s_ack_i | s_err_i | s_rty_i;

   rr_pick2 u_pick (
      .req  ({w_req1, w_req0}),
      .last (r_last),
      .pick (w_pick)
   );

`ifdef WB_ARB2_TIMEOUT_EN
   localparam logic [TIMEOUT_CW-1:0] LP_TO_LAST = TIMEOUT_CW'(TIMEOUT - 1);

   logic [TIMEOUT_CW-1:0] r_cnt;
   logic                  w_own_stb;

   assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
   // A strobe still outstanding at the limit with no response this cycle trips.
   assign w_to_hit  = w_own_stb & ~w_resp & (r_cnt == LP_TO_LAST);

   // Count consecutive cycles the owner's strobe waits without a response.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !(w_own0 || w_own1) || !w_own_stb || w_resp)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_to_hit = 1'b0;
`endif

   // Next-state: grant from IDLE, release on owner CYC drop, abort on watchdog.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_pick[0])      w_state_nxt = OWN0;
            else if (w_pick[1]) w_state_nxt = OWN1;
         end
         OWN0: begin
            if (!m0_cyc_i) begin
               w_last_nxt  = 1'b0;
               w_state_nxt = w_req1 ? OWN1 : IDLE;
            end else if (w_to_hit) begin
               w_last_nxt  = 1'b0;
               w_state_nxt = ABORT;
            end
         end
         OWN1: begin
            if (!m1_cyc_i) begin
               w_last_nxt  = 1'b1;
               w_state_nxt = w_req0 ? OWN0 : IDLE;
            end else if (w_to_hit) begin
               w_last_nxt  = 1'b1;
               w_state_nxt = ABORT;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and last-owner registers; last resets to m1 so m0 wins the first tie.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign gnt_o     = gnt_of(r_state);
   assign m0_data_o = s_data_i;
   assign m1_data_o = s_data_i;

   // Owner mux: slave side mirrors the owner, responses go back to the owner only.
   always_comb begin
      s_addr_o = '0;
      s_data_o = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      if (w_own0) begin
         s_addr_o = m0_addr_i;
         s_data_o = m0_data_i;
         s_sel_o  = m0_sel_i;
         s_we_o   = m0_we_i;
         s_cyc_o  = m0_cyc_i;
         s_stb_o  = m0_stb_i;
         m0_ack_o = s_ack_i & m0_stb_i;
         m0_err_o = (s_err_i & m0_stb_i) | w_to_hit;
         m0_rty_o = s_rty_i & m0_stb_i;
      end else if (w_own1) begin
         s_addr_o = m1_addr_i;
         s_data_o = m1_data_i;
         s_sel_o  = m1_sel_i;
         s_we_o   = m1_we_i;
         s_cyc_o  = m1_cyc_i;
         s_stb_o  = m1_stb_i;
         m1_ack_o = s_ack_i & m1_stb_i;
         m1_err_o = (s_err_i & m1_stb_i) | w_to_hit;
         m1_rty_o = s_rty_i & m1_stb_i;
      end
   end

endmodule
